// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button debouncer.
package btn_pkg;

    // Debouncer FSM states: two stable levels, each with a qualifying wait state.
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    // The button is active-low: 0 means pressed.
    localparam logic BTN_PRESSED  = 1'b0;
    localparam logic BTN_RELEASED = 1'b1;

endpackage

// File: rtl/button_debouncer_if.sv
// Button-side signal bundle: raw input towards the debouncer and its
// conditioned outputs. The release strobe is named release_strobe because
// "release" is a reserved word in SystemVerilog.
interface button_debouncer_if;

    logic select_raw;
    logic select_clean;
    logic press;
    logic release_strobe;

    // Board side: drives the raw button and consumes the conditioned outputs.
    modport master (
        output select_raw,
        input  select_clean,
        input  press,
        input  release_strobe
    );

    // Debouncer side.
    modport slave (
        input  select_raw,
        output select_clean,
        output press,
        output release_strobe
    );

endinterface

// File: rtl/button_debouncer_sync_chain.sv
// Metastability synchronizer: STAGES flip-flops in series, reset to released.
module sync_chain
    import btn_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Shift the asynchronous input one stage further each cycle.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    // Chain registers; reset to the released level so no false press appears.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= {STAGES{BTN_RELEASED}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes the raw active-low button, requires
// DEBOUNCE_CYCLES stable synchronized cycles in a wait state before the
// clean level changes, and emits one-cycle press/release strobes.
module button_debouncer
    import btn_pkg::*;
#(
    parameter  int SYNC_STAGES     = 2,
    parameter  int DEBOUNCE_CYCLES = 500000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    button_debouncer_if.slave   btn
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_q;
    deb_state_t       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             clean_q,   clean_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn.select_raw),
        .q     (sync_q)
    );

    // Next-state, stability counter and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (sync_q == BTN_PRESSED) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = RELEASED;
                end
            end
            PRESS_WAIT: begin
                if (sync_q == BTN_RELEASED) begin
                    state_d = RELEASED;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = CNT_ZERO;
                    press_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (sync_q == BTN_RELEASED) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = PRESSED;
                end
            end
            RELEASE_WAIT: begin
                if (sync_q == BTN_PRESSED) begin
                    state_d = PRESSED;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASED;
                    cnt_d     = CNT_ZERO;
                    release_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = CNT_ZERO;
            end
        endcase

        if ((state_d == PRESSED) || (state_d == RELEASE_WAIT)) begin
            clean_d = BTN_PRESSED;
        end else begin
            clean_d = BTN_RELEASED;
        end
    end

    // State, counter and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RELEASED;
            cnt_q     <= CNT_ZERO;
            clean_q   <= BTN_RELEASED;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn.select_clean   = clean_q;
    assign btn.press          = press_q;
    assign btn.release_strobe = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Reference model: the FSM-visible input is the raw sample SYNC edges old;
// the clean level flips once the visible input has disagreed with it on
// DEB+1 consecutive edges (one edge to leave the stable state, DEB to qualify).
module tb_button_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic reset;

    button_debouncer_if btn ();

    button_debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (btn)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic pipe_m [SYNC];
    logic clean_m;
    logic press_m;
    logic rel_m;
    int   run_m;

    // Scenario bookkeeping
    int   edge_no;
    int   first_press;
    int   first_rel;
    int   press_cnt;
    int   rel_cnt;
    int   fall_cnt;
    logic prev_clean;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Predict the outputs that follow the coming clock edge.
    task automatic model_edge(input logic raw, input logic rst);
        logic seen;
        press_m = 1'b0;
        rel_m   = 1'b0;
        if (rst) begin
            for (int i = 0; i < SYNC; i++) pipe_m[i] = 1'b1;
            clean_m = 1'b1;
            run_m   = 0;
        end else begin
            seen = pipe_m[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) pipe_m[i] = pipe_m[i-1];
            pipe_m[0] = raw;
            if (seen != clean_m) begin
                run_m++;
                if (run_m == DEB + 1) begin
                    clean_m = seen;
                    run_m   = 0;
                    if (seen == 1'b0) press_m = 1'b1;
                    else              rel_m   = 1'b1;
                end
            end else begin
                run_m = 0;
            end
        end
    endtask

    // One clock: drive on the falling edge, check just after the rising edge.
    task automatic step(input logic raw, input logic rst);
        @(negedge clk);
        btn.select_raw = raw;
        reset          = rst;
        model_edge(raw, rst);
        @(posedge clk);
        #1;
        edge_no++;
        check("select_clean", btn.select_clean,   clean_m);
        check("press",        btn.press,          press_m);
        check("release",      btn.release_strobe, rel_m);
        if (btn.press === 1'b1) begin
            press_cnt++;
            if (first_press < 0) first_press = edge_no;
        end
        if (btn.release_strobe === 1'b1) begin
            rel_cnt++;
            if (first_rel < 0) first_rel = edge_no;
        end
        if ((prev_clean === 1'b1) && (btn.select_clean === 1'b0)) fall_cnt++;
        prev_clean = btn.select_clean;
    endtask

    task automatic hold(input logic raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b0);
    endtask

    task automatic mark();
        edge_no     = 0;
        first_press = -1;
        first_rel   = -1;
        press_cnt   = 0;
        rel_cnt     = 0;
        fall_cnt    = 0;
    endtask

    initial begin
        logic lvl;
        int   len;
        reset          = 1'b1;
        btn.select_raw = 1'b1;
        prev_clean     = 1'b1;
        mark();

        // Reset for two cycles: released, no strobes.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("reset_clean", btn.select_clean, 1'b1);

        // Clean press: press and clean fall after edge 7, press gone after 8.
        mark();
        hold(1'b0, 10);
        check_int("press_edge",  first_press, 7);
        check_int("press_count", press_cnt,   1);
        check_int("rel_in_press", rel_cnt,    0);

        // Clean release: symmetric, one release pulse after edge 7.
        mark();
        hold(1'b1, 10);
        check_int("release_edge",  first_rel, 7);
        check_int("release_count", rel_cnt,   1);

        // Bounce rejection while released.
        mark();
        hold(1'b0, 3);
        hold(1'b1, 2);
        hold(1'b0, 2);
        hold(1'b1, 10);
        check_int("bounce_press", press_cnt, 0);
        check_int("bounce_fall",  fall_cnt,  0);

        // Release bounce while pressed.
        hold(1'b0, 10);
        mark();
        hold(1'b1, 2);
        hold(1'b0, 8);
        check_int("rbounce_release", rel_cnt, 0);
        check("rbounce_clean", btn.select_clean, 1'b0);
        hold(1'b1, 10);

        // Reset mid-wait discards the press; a held button then needs 7 edges.
        hold(1'b0, 5);
        step(1'b0, 1'b1);
        check("midreset_clean", btn.select_clean, 1'b1);
        check("midreset_press", btn.press, 1'b0);
        mark();
        hold(1'b0, 10);
        check_int("midreset_press_edge", first_press, 7);
        hold(1'b1, 10);

        // Three full press/release cycles.
        mark();
        for (int k = 0; k < 3; k++) begin
            hold(1'b0, 10);
            hold(1'b1, 10);
        end
        check_int("rep_press",   press_cnt, 3);
        check_int("rep_release", rel_cnt,   3);
        check_int("rep_falls",   fall_cnt,  3);

        // Randomized bouncy segments with occasional resets.
        for (int s = 0; s < 120; s++) begin
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) begin
                step(lvl, ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream conditioning stage for the press counter on the practice board.
- Samples a raw, bouncy, asynchronous, active-low push-button.
- Produces a debounced active-low level plus one-cycle press and release strobes, all synchronous to clk.
- select_clean connects directly to the counter's select input.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the metastability synchronizer; must be ≥2.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized cycles required before the debounced level changes (10 ms at 50 MHz); must be ≥1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of the stability counter; derived, not overridden.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- select_raw  input  1  raw asynchronous button; 0 = pressed
- select_clean  output  1  debounced level; 0 = pressed
- press  output  1  one-cycle strobe on debounced press (1→0 of select_clean)
- release  output  1  one-cycle strobe on debounced release (0→1 of select_clean)

Behaviour:
- Reset (synchronous, sampled at a clk edge):
  - all synchronizer flops = 1 (released);
  - state = RELEASED, counter = 0;
  - select_clean = 1, press = 0, release = 0.
- Synchronizer:
  - SYNC_STAGES-deep chain on select_raw.
  - Its last stage, sync_q, is the only signal the FSM reads.
  - No other logic touches select_raw.
- FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: sync_q=0 → PRESS_WAIT, counter=0; else stay.
  - PRESS_WAIT, sync_q=1 (bounce): → RELEASED, counter=0, no strobe.
  - PRESS_WAIT, sync_q=0 and counter==DEBOUNCE_CYCLES-1: → PRESSED.
  - PRESS_WAIT, sync_q=0 otherwise: counter+1.
  - PRESSED: sync_q=1 → RELEASE_WAIT, counter=0; else stay.
  - RELEASE_WAIT, sync_q=0 (bounce): → PRESSED, counter=0, no strobe.
  - RELEASE_WAIT, sync_q=1 and counter==DEBOUNCE_CYCLES-1: → RELEASED.
  - RELEASE_WAIT, sync_q=1 otherwise: counter+1.
- Outputs (all registered, no combinational path from select_raw):
  - select_clean = 0 in PRESSED and RELEASE_WAIT, 1 in RELEASED and PRESS_WAIT.
  - press = 1 for exactly the cycle following the PRESS_WAIT→PRESSED edge.
  - release = 1 for exactly the cycle following the RELEASE_WAIT→RELEASED edge.
  - press and release are never both 1; never 1 in consecutive cycles for the same event.
- Latency: let edge 1 be the first edge that samples select_raw=0, with the input held stable thereafter.
  - select_clean falls and press rises after edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
  - press falls one edge later.
  - Release timing is symmetric.
- Counter:
  - Never exceeds DEBOUNCE_CYCLES-1.
  - Cleared on every state change; no wrap-around possible.
- Bounce shorter than DEBOUNCE_CYCLES stable synchronized cycles: no change on select_clean and no strobe.
- DEBOUNCE_CYCLES=1: one stable synchronized cycle in the wait state suffices.
- Reset mid-operation (any state, any counter value): next cycle matches the reset values above. A press in progress is discarded with no strobe.
- Reset has priority over all other events in the same cycle.

Decomposition:
- Shared package btn_pkg:
  - typedef enum logic [1:0] deb_state_t {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT};
  - localparam BTN_PRESSED = 1'b0, BTN_RELEASED = 1'b1.
- One sub-module, sync_chain:
  - parameter STAGES;
  - ports clk, reset, d, q;
  - reset value 1.
- FSM, counter and output registers live in button_debouncer.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Clean press: reset for 2 cycles, then select_raw=0 held → select_clean goes 0 and press=1 after edge 7; press=0 after edge 8; release stays 0.
- Bounce rejection: select_raw=0 for 3 cycles, 1 for 2, 0 for 2, then 1 → select_clean stays 1; press never asserts.
- Clean release: from PRESSED, select_raw=1 held → select_clean=1 and release=1 after edge 7 of the release; exactly one release pulse.
- Release bounce: in PRESSED, select_raw=1 for 2 cycles then 0 → select_clean stays 0; no release; state returns to PRESSED.
- Reset mid-wait: select_raw=0 for 5 cycles (PRESS_WAIT, counter=2), reset=1 for one cycle → next cycle select_clean=1, press=0, counter=0. A held button then needs a full 7 edges after reset deasserts to produce press.
- Repeated presses: 3 full press/release cycles of 10 stable cycles each → exactly 3 press and 3 release pulses. A counter downstream of select_clean reads 3.
